// File: rtl/seg_scan_pwm.sv
// ============================================================================
// Module   : seg_scan_pwm
// Brief    : Multiplexed 7-segment scanner with per-slot blanking and PWM
//            brightness. Optional leading-zero suppression when the macro
//            SEG_SCAN_LZ_SUPPRESS_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg_scan_pwm #(
    parameter int DIGITS    = 8,
    parameter int SCAN_CYC  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic [DIGITS-1:0]     dp,
    input  logic [3:0]            bright,
    output logic [DIGITS-1:0]     sel,
    output logic [7:0]            seg,
    output logic                  frame_done
);

    // The counter is kept at least 4 bits wide so the PWM phase slice is legal.
    localparam int CNT_W = ($clog2(SCAN_CYC) < 4) ? 4 : $clog2(SCAN_CYC);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(SCAN_CYC - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_BLANK    = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);

    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [3:0]        r_snap_code;
    logic              r_snap_dp;
    logic [DIGITS-1:0] r_sel;
    logic [7:0]        r_seg;
    logic              r_frame_done;

    logic              w_cnt_wrap;
    logic              w_last_digit;
    logic              w_blank_phase;
    logic [3:0]        w_nib;
    logic              w_dp_bit;
    logic [DIGITS-1:0] w_sel_n;
    logic [3:0]        w_code_eff;
    logic [3:0]        w_pwm_phase;
    logic              w_pwm_lit;
    logic [7:0]        w_seg_lit;

    function automatic logic [7:0] f_decode(input logic [3:0] code);
        logic [7:0] pat;
        case (code)
            4'd0:    pat = 8'hC0;
            4'd1:    pat = 8'hF9;
            4'd2:    pat = 8'hA4;
            4'd3:    pat = 8'hB0;
            4'd4:    pat = 8'h99;
            4'd5:    pat = 8'h92;
            4'd6:    pat = 8'h82;
            4'd7:    pat = 8'hF8;
            4'd8:    pat = 8'h80;
            4'd9:    pat = 8'h90;
            4'd10:   pat = 8'hFF;
            4'd11:   pat = 8'hBF;
            4'd12:   pat = 8'hC6;
            4'd13:   pat = 8'h89;
            4'd14:   pat = 8'hC7;
            default: pat = 8'h8C;
        endcase
        return pat;
    endfunction

    assign w_cnt_wrap    = (r_cnt == c_CNT_LAST);
    assign w_last_digit  = (r_idx == c_IDX_LAST);
    assign w_blank_phase = (r_cnt < c_BLANK);

    // Mux the current digit's nibble, dp bit and active-low select.
    always_comb begin
        w_nib    = 4'd0;
        w_dp_bit = 1'b0;
        w_sel_n  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib      = digits[i*4 +: 4];
                w_dp_bit   = dp[i];
                w_sel_n[i] = 1'b0;
            end
        end
    end

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    logic w_hi_zero;

    always_comb begin
        w_hi_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if ((i > int'(r_idx)) && (digits[i*4 +: 4] != 4'd0)) begin
                w_hi_zero = 1'b0;
            end
        end
    end

    // A suppressed zero is stored as the blank code so dp still applies.
    assign w_code_eff = ((w_nib == 4'd0) && (r_idx != '0) && w_hi_zero) ? 4'd10 : w_nib;
`else
    assign w_code_eff = w_nib;
`endif

    // Mod-16 position within the ON phase; only the low nibble matters.
    assign w_pwm_phase = r_cnt[3:0] - c_BLANK[3:0];
    assign w_pwm_lit   = (w_pwm_phase <= bright);
    assign w_seg_lit   = f_decode(r_snap_code) & {~r_snap_dp, 7'h7F};

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_snap_code  <= 4'd0;
            r_snap_dp    <= 1'b0;
            r_sel        <= '1;
            r_seg        <= 8'hFF;
            r_frame_done <= 1'b0;
        end else if (!en) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_sel        <= '1;
            r_seg        <= 8'hFF;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt <= w_cnt_wrap ? '0 : r_cnt + c_CNT_ONE;
            if (w_cnt_wrap) begin
                r_idx <= w_last_digit ? '0 : r_idx + c_IDX_ONE;
            end
            if (r_cnt == '0) begin
                r_snap_code <= w_code_eff;
                r_snap_dp   <= w_dp_bit;
            end
            r_frame_done <= w_cnt_wrap && w_last_digit;
            if (w_blank_phase) begin
                r_sel <= '1;
                r_seg <= 8'hFF;
            end else begin
                r_sel <= w_sel_n;
                r_seg <= w_pwm_lit ? w_seg_lit : 8'hFF;
            end
        end
    end

    assign sel        = r_sel;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire
